gte_sel_add_seq: RTL

- Parametrised, sequenced successor of the GTE add-path operand selector.
- On a start pulse, latches the operand-select controls and computes the shared SZ0*ZSF4 product in a registered stage.
- Then emits one fixed-point add operand per channel, channel 0..CH_COUNT-1, over a valid/ready stream into the MAC adder stage.
- Sits between the GTE register file and the MAC accumulate unit.

---
 rtl/gte_sel_add_seq_if.sv | 15 +
 rtl/gte_sel_add_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gte_sel_add_seq_if.sv
// Operand stream from the GTE add-path selector into the MAC adder stage.
// The master drives valid/id/last/operand; the slave returns ready.
interface gte_sel_add_seq_if #(
  parameter int ID_W  = 2,
  parameter int OUT_W = 44
);
  logic             o_valid;
  logic             i_ready;
  logic [ID_W-1:0]  o_id;
  logic             o_last;
  logic [OUT_W-1:0] o_operand;

  modport master (output o_valid, o_id, o_last, o_operand, input i_ready);
  modport slave  (input o_valid, o_id, o_last, o_operand, output i_ready);
endinterface

// File: rtl/gte_sel_add_seq.sv
// Sequenced GTE add-path operand selector: one fixed-point operand per channel per sequence.
// Optional macro GTE_SELADD_NEG_EN adds i_neg, which negates every emitted operand.
//
// state | meaning
// IDLE  | waiting for i_start; controls latched on the start edge
// PREP  | SZ0*ZSF4 product registered, channel 0 operand loaded
// EMIT  | o_valid high, one operand per accepted handshake
module gte_sel_add_seq #(
  parameter int CH_COUNT = 3,
  parameter int INT_W    = 32,
  parameter int FRAC_W   = 12,
  parameter int ID_W     = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [3:0]                i_sel,
  input  logic                      i_isMVMVA,
  input  logic [1:0]                i_cv,
  input  logic                      i_sf,
  input  logic                      i_useSF,
  input  logic [CH_COUNT*INT_W-1:0] i_tr,
  input  logic [CH_COUNT*INT_W-1:0] i_bk,
  input  logic [CH_COUNT*INT_W-1:0] i_fc,
  input  logic [CH_COUNT*INT_W-1:0] i_mac,
  input  logic [CH_COUNT*INT_W-1:0] i_of,
  input  logic [CH_COUNT*8-1:0]     i_col,
  input  logic [CH_COUNT*16-1:0]    i_tmp,
  input  logic [15:0]               i_sz0,
  input  logic [15:0]               i_zsf4,
  input  logic [23:0]               i_special,
`ifdef GTE_SELADD_NEG_EN
  input  logic                      i_neg,
`endif
  output logic                      o_busy,
  gte_sel_add_seq_if.master         strm
);

  localparam int OUT_W = INT_W + FRAC_W;
  localparam logic [ID_W-1:0] K_LAST = ID_W'(CH_COUNT - 1);

  typedef enum logic [1:0] {IDLE, PREP, EMIT} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   k_q, k_d;
  logic [3:0]        effsel_q, effsel_d;
  logic              vsf_q, vsf_d;
  logic signed [32:0] prod_q, prod_d;
  logic [OUT_W-1:0]  operand_q, operand_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              last_q, last_d;
`ifdef GTE_SELADD_NEG_EN
  logic              neg_q, neg_d;
`endif

  logic signed [16:0] sz0_s, zsf4_s;
  logic signed [32:0] prod_live, prod_sel;
  logic [ID_W-1:0]    ch;
  logic [INT_W-1:0]   tr_c, bk_c, fc_c, mac_c, of_c;
  logic [7:0]         col_c;
  logic [15:0]        tmp_c;
  logic [OUT_W-1:0]   op_raw, op_next;

  assign sz0_s     = {1'b0, i_sz0};
  assign zsf4_s    = {i_zsf4[15], i_zsf4};
  assign prod_live = 33'(sz0_s) * 33'(zsf4_s);
  // The channel-0 load happens on the same edge that registers the product.
  assign prod_sel  = (state_q == PREP) ? prod_live : prod_q;

  assign ch    = (state_q == PREP) ? '0 : ID_W'(k_q + 1'b1);
  assign tr_c  = i_tr[ch*INT_W +: INT_W];
  assign bk_c  = i_bk[ch*INT_W +: INT_W];
  assign fc_c  = i_fc[ch*INT_W +: INT_W];
  assign mac_c = i_mac[ch*INT_W +: INT_W];
  assign of_c  = i_of[ch*INT_W +: INT_W];
  assign col_c = i_col[ch*8 +: 8];
  assign tmp_c = i_tmp[ch*16 +: 16];

  always_comb begin
    op_raw = '0;
    case (effsel_q)
      4'd0:    op_raw = {tr_c, {FRAC_W{1'b0}}};
      4'd1:    op_raw = {bk_c, {FRAC_W{1'b0}}};
      4'd2:    op_raw = {fc_c, {FRAC_W{1'b0}}};
      4'd4:    op_raw = OUT_W'(col_c) << (FRAC_W + 4);
      4'd5:    op_raw = vsf_q ? {mac_c, {FRAC_W{1'b0}}} : OUT_W'($signed(mac_c));
      4'd6:    op_raw = OUT_W'(prod_sel);
      4'd7:    op_raw = OUT_W'(tmp_c) << FRAC_W;
      4'd8:    op_raw = OUT_W'($signed(of_c));
      4'd9:    op_raw = OUT_W'($signed(i_special)) << 4;
      default: op_raw = '0;
    endcase
  end

`ifdef GTE_SELADD_NEG_EN
  assign op_next = neg_q ? -op_raw : op_raw;
`else
  assign op_next = op_raw;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      effsel_q  <= '0;
      vsf_q     <= 1'b0;
      prod_q    <= '0;
      operand_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
`ifdef GTE_SELADD_NEG_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      effsel_q  <= effsel_d;
      vsf_q     <= vsf_d;
      prod_q    <= prod_d;
      operand_q <= operand_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
`ifdef GTE_SELADD_NEG_EN
      neg_q     <= neg_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    effsel_d  = effsel_q;
    vsf_d     = vsf_q;
    prod_d    = prod_q;
    operand_d = operand_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    last_d    = last_q;
`ifdef GTE_SELADD_NEG_EN
    neg_d     = neg_q;
`endif
    if (i_abort) begin
      state_d = IDLE;
      k_d     = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d  = PREP;
            effsel_d = i_isMVMVA ? {2'b00, i_cv} : i_sel;
            vsf_d    = i_sf & i_useSF;
            busy_d   = 1'b1;
`ifdef GTE_SELADD_NEG_EN
            neg_d    = i_neg;
`endif
          end
        end
        PREP: begin
          state_d   = EMIT;
          prod_d    = prod_live;
          operand_d = op_next;
          k_d       = '0;
          valid_d   = 1'b1;
          last_d    = (K_LAST == '0);
        end
        EMIT: begin
          if (strm.i_ready) begin
            if (k_q == K_LAST) begin
              state_d = IDLE;
              k_d     = '0;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              last_d  = 1'b0;
            end else begin
              k_d       = ID_W'(k_q + 1'b1);
              operand_d = op_next;
              last_d    = (ID_W'(k_q + 1'b1) == K_LAST);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_busy         = busy_q;
  assign strm.o_valid   = valid_q;
  assign strm.o_id      = k_q;
  assign strm.o_last    = last_q;
  assign strm.o_operand = operand_q;

endmodule
